// File: rtl/maze_pkg.sv
// Shared definitions for the depth-first maze solver.
//   DIR_*      : 2-bit move encodings (try order UP, RIGHT, LEFT, DOWN)
//   state_t    : solver FSM state encoding
//   opposite() : reverse of a move; the encoding makes it the bitwise complement
package maze_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;   // y+1
    localparam logic [1:0] DIR_RIGHT = 2'b01;   // x+1
    localparam logic [1:0] DIR_LEFT  = 2'b10;   // x-1
    localparam logic [1:0] DIR_DOWN  = 2'b11;   // y-1

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MARK,
        ST_PROBE,
        ST_WAIT,
        ST_ADV,
        ST_BACK,
        ST_DONE,
        ST_REPLAY,
        ST_FAIL
    } state_t;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        return ~d;
    endfunction

endpackage

// File: rtl/dir_stack.sv
// LIFO of 2-bit moves used as the DFS path stack.
//   clk, reset : clock, synchronous active-high reset (empties the stack)
//   clear      : empty the stack (new search)
//   push/pop   : push push_dir / drop the top entry (caller guards full/empty)
//   top_dir    : entry at sp-1 (the move to undo on a pop)
//   rd_idx     : indexed read for path replay, result on rd_dir
//   sp         : number of stored entries; full/empty flags
module dir_stack #(
    parameter int STACK_DEPTH = 256,
    parameter int SP_W        = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [1:0]      push_dir,
    input  logic [SP_W-1:0] rd_idx,
    output logic [1:0]      top_dir,
    output logic [1:0]      rd_dir,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty
);

    logic [1:0]      entry_reg [STACK_DEPTH];
    logic [SP_W-1:0] sp_reg;
    logic [SP_W-1:0] sp_m1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sp_reg <= '0;
        end else if (push) begin
            sp_reg <= sp_reg + 1'b1;
        end else if (pop) begin
            sp_reg <= sp_reg - 1'b1;
        end
    end

    // Storage carries no reset: contents above sp are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_reg == SP_W'(i)) entry_reg[i] <= push_dir;
            end
        end
    end

    assign sp_m1 = sp_reg - 1'b1;

    // Full-width compares keep the read ports well defined even when sp
    // is wider than the entry index.
    always_comb begin
        top_dir = '0;
        rd_dir  = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_m1 == SP_W'(i))  top_dir = entry_reg[i];
            if (rd_idx == SP_W'(i)) rd_dir  = entry_reg[i];
        end
    end

    assign sp    = sp_reg;
    assign full  = (sp_reg == SP_W'(STACK_DEPTH));
    assign empty = (sp_reg == '0);

endmodule

// File: rtl/maze_dfs_solver.sv
// Depth-first maze solver over a 2**X_W x 2**Y_W bit-map (1 = wall/visited)
// held in external 1-bit memory, followed by a valid/ready replay of the path.
//   clk, reset          : clock, synchronous active-high reset
//   start, goal_x/y     : launch a search (sampled in IDLE only)
//   mem_addr/rd/rdata   : {y,x} cell read, data valid the cycle after mem_rd
//   mem_wr/wdata        : mark the current cell visited
//   busy, done, fail    : search in progress / path found / no path
//   ovf                 : last failure was a stack overflow (sticky until start)
//   path_valid/dir/last : replay stream of moves, oldest first
//   path_ready          : consumer handshake
module maze_dfs_solver #(
    parameter int X_W         = 4,
    parameter int Y_W         = 4,
    parameter int STACK_DEPTH = 256,
    parameter int SP_W        = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     goal_x,
    input  logic [Y_W-1:0]     goal_y,
    output logic [Y_W+X_W-1:0] mem_addr,
    output logic               mem_rd,
    input  logic               mem_rdata,
    output logic               mem_wr,
    output logic               mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic               ovf,
    output logic               path_valid,
    output logic [1:0]         path_dir,
    output logic               path_last,
    input  logic               path_ready
);
    import maze_pkg::*;

    localparam logic [X_W-1:0] X_MAX = '1;
    localparam logic [Y_W-1:0] Y_MAX = '1;

    state_t          state_reg, state_next;
    logic [X_W-1:0]  x_reg, x_next, gx_reg, gx_next;
    logic [Y_W-1:0]  y_reg, y_next, gy_reg, gy_next;
    logic [1:0]      d_reg, d_next;
    logic            ovf_reg, ovf_next;
    logic [SP_W-1:0] idx_reg, idx_next;

    logic            push, pop, clear;
    logic [1:0]      top_dir, rd_dir;
    logic [SP_W-1:0] sp, sp_last;
    logic            full, empty;

    logic [1:0]      step_dir;
    logic [X_W-1:0]  nx;
    logic [Y_W-1:0]  ny;
    logic            blocked;

    dir_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .SP_W        (SP_W)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (push),
        .pop      (pop),
        .push_dir (d_reg),
        .rd_idx   (idx_reg),
        .top_dir  (top_dir),
        .rd_dir   (rd_dir),
        .sp       (sp),
        .full     (full),
        .empty    (empty)
    );

    assign sp_last = sp - 1'b1;

    // One shared stepper: forward along d while exploring, along the
    // reverse of the popped move while backtracking. The bound test is
    // made on the current coordinate so x/y never wrap.
    always_comb begin
        step_dir = (state_reg == ST_BACK) ? opposite(top_dir) : d_reg;
        nx       = x_reg;
        ny       = y_reg;
        blocked  = 1'b0;
        case (step_dir)
            DIR_UP:    begin blocked = (y_reg == Y_MAX); ny = y_reg + 1'b1; end
            DIR_RIGHT: begin blocked = (x_reg == X_MAX); nx = x_reg + 1'b1; end
            DIR_LEFT:  begin blocked = (x_reg == '0);    nx = x_reg - 1'b1; end
            default:   begin blocked = (y_reg == '0);    ny = y_reg - 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            gx_reg    <= '0;
            gy_reg    <= '0;
            d_reg     <= DIR_UP;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            gx_reg    <= gx_next;
            gy_reg    <= gy_next;
            d_reg     <= d_next;
            ovf_reg   <= ovf_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        gx_next    = gx_reg;
        gy_next    = gy_reg;
        d_next     = d_reg;
        ovf_next   = ovf_reg;
        idx_next   = idx_reg;
        push       = 1'b0;
        pop        = 1'b0;
        clear      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        fail       = 1'b0;
        path_valid = 1'b0;
        path_last  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    gx_next    = goal_x;
                    gy_next    = goal_y;
                    x_next     = '0;
                    y_next     = '0;
                    ovf_next   = 1'b0;
                    clear      = 1'b1;
                    state_next = ST_MARK;
                end
            end
            ST_MARK: begin
                busy   = 1'b1;
                mem_wr = 1'b1;
                if (x_reg == gx_reg && y_reg == gy_reg) begin
                    state_next = ST_DONE;
                end else begin
                    d_next     = DIR_UP;
                    state_next = ST_PROBE;
                end
            end
            ST_PROBE: begin
                busy = 1'b1;
                if (blocked) begin
                    if (d_reg == DIR_DOWN) state_next = ST_BACK;
                    else                   d_next     = d_reg + 2'd1;
                end else begin
                    mem_rd     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (mem_rdata) begin
                    if (d_reg == DIR_DOWN) begin
                        state_next = ST_BACK;
                    end else begin
                        d_next     = d_reg + 2'd1;
                        state_next = ST_PROBE;
                    end
                end else begin
                    state_next = ST_ADV;
                end
            end
            ST_ADV: begin
                busy = 1'b1;
                if (full) begin
                    ovf_next   = 1'b1;
                    state_next = ST_FAIL;
                end else begin
                    push       = 1'b1;
                    x_next     = nx;
                    y_next     = ny;
                    state_next = ST_MARK;
                end
            end
            ST_BACK: begin
                busy = 1'b1;
                if (empty) begin
                    state_next = ST_FAIL;
                end else begin
                    pop    = 1'b1;
                    x_next = nx;
                    y_next = ny;
                    // A popped DOWN means the parent cell is exhausted too:
                    // stay here and pop again.
                    if (top_dir != DIR_DOWN) begin
                        d_next     = top_dir + 2'd1;
                        state_next = ST_PROBE;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                idx_next   = '0;
                state_next = empty ? ST_IDLE : ST_REPLAY;
            end
            ST_REPLAY: begin
                path_valid = 1'b1;
                path_last  = (idx_reg == sp_last);
                if (path_ready) begin
                    if (path_last) state_next = ST_IDLE;
                    else           idx_next   = idx_reg + 1'b1;
                end
            end
            ST_FAIL: begin
                fail       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_addr  = (state_reg == ST_PROBE || state_reg == ST_WAIT) ? {ny, nx} : {y_reg, x_reg};
    assign mem_wdata = 1'b1;
    assign ovf       = ovf_reg;
    assign path_dir  = path_valid ? rd_dir : 2'b00;

endmodule
